// File: rtl/fetch_insn_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_insn_queue_if
//   Bundles the fetch-side enqueue bus and the pre-decode dequeue bus of the
//   fetch instruction queue.
//
//   Enqueue side (driven by fetch, master):
//     in_valid       [IN_WIDTH]            per-lane valid, lane 0 = oldest PC
//     in_pc          [IN_WIDTH*PC_WIDTH]   per-lane PC
//     in_insn        [IN_WIDTH*INSN_WIDTH] per-lane instruction word
//     in_pred_taken  [IN_WIDTH]            per-lane predicted-taken flag
//     in_ready       (from queue)          a full bundle can be accepted
//   Dequeue side:
//     out_valid      [OUT_WIDTH]           entry i valid, oldest first
//     out_pc / out_insn / out_pred_taken   oldest OUT_WIDTH entries
//     deq_count      (to queue)            entries consumed this cycle
//     occupancy      (from queue)          registered number of valid entries
// -----------------------------------------------------------------------------
interface fetch_insn_queue_if #(
  parameter int IN_WIDTH   = 2,
  parameter int OUT_WIDTH  = 2,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32,
  parameter int INSN_WIDTH = 32
);
  logic [IN_WIDTH-1:0]              in_valid;
  logic [IN_WIDTH*PC_WIDTH-1:0]     in_pc;
  logic [IN_WIDTH*INSN_WIDTH-1:0]   in_insn;
  logic [IN_WIDTH-1:0]              in_pred_taken;
  logic                             in_ready;

  logic [OUT_WIDTH-1:0]             out_valid;
  logic [OUT_WIDTH*PC_WIDTH-1:0]    out_pc;
  logic [OUT_WIDTH*INSN_WIDTH-1:0]  out_insn;
  logic [OUT_WIDTH-1:0]             out_pred_taken;
  logic [$clog2(OUT_WIDTH+1)-1:0]   deq_count;
  logic [$clog2(DEPTH+1)-1:0]       occupancy;

  // Fetch/pre-decode side.
  modport master (
    output in_valid, in_pc, in_insn, in_pred_taken, deq_count,
    input  in_ready, out_valid, out_pc, out_insn, out_pred_taken, occupancy
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_insn, in_pred_taken, deq_count,
    output in_ready, out_valid, out_pc, out_insn, out_pred_taken, occupancy
  );
endinterface

// File: rtl/fetch_insn_queue.sv
// -----------------------------------------------------------------------------
// fetch_insn_queue
//   Circular instruction queue between fetch and pre-decode. Accepts a bundle
//   of up to IN_WIDTH lanes per cycle, drops lanes that follow the first
//   predicted-taken valid lane, compacts the surviving lanes into consecutive
//   entries, and presents the oldest OUT_WIDTH entries to pre-decode.
//
//   Ports:
//     clk    rising-edge clock for all state
//     rst    synchronous active-high reset (highest priority)
//     flush  drop all queued entries and this cycle's incoming bundle
//     bus    fetch_insn_queue_if.slave (enqueue/dequeue buses, occupancy)
// -----------------------------------------------------------------------------
module fetch_insn_queue #(
  parameter int IN_WIDTH   = 2,
  parameter int OUT_WIDTH  = 2,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32,
  parameter int INSN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  fetch_insn_queue_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Entry payload; never reset, only the pointers/occupancy define validity.
  logic [PC_WIDTH-1:0]   pcMem    [DEPTH];
  logic [INSN_WIDTH-1:0] insnMem  [DEPTH];
  logic                  takenMem [DEPTH];

  logic [PTR_W-1:0] headReg, headNext;
  logic [PTR_W-1:0] tailReg, tailNext;
  logic [OCC_W-1:0] occReg,  occNext;

  logic [IN_WIDTH-1:0] effLane;
  // laneOffset[i] = number of effective lanes below lane i, i.e. the write
  // slot of lane i relative to tail. laneOffset[IN_WIDTH] is the total.
  logic [PTR_W-1:0]    laneOffset [IN_WIDTH+1];
  logic                takenSeen;
  logic [OCC_W-1:0]    enqCount;
  logic [OCC_W-1:0]    deqEff;
  logic [OCC_W-1:0]    freeSlots;
  logic                inReady;
  logic                doEnq;

  // ---------------------------------------------------------------------------
  // Effective-lane selection and compaction offsets
  // ---------------------------------------------------------------------------
  always_comb begin
    takenSeen     = 1'b0;
    effLane       = '0;
    laneOffset[0] = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      // A lane survives only if no older valid lane was predicted taken.
      effLane[i]      = bus.in_valid[i] & ~takenSeen;
      takenSeen       = takenSeen | (bus.in_valid[i] & bus.in_pred_taken[i]);
      laneOffset[i+1] = laneOffset[i] + PTR_W'(effLane[i]);
    end
  end

  assign enqCount = OCC_W'(laneOffset[IN_WIDTH]);

  // Ready looks only at the registered occupancy, so a bundle is never
  // accepted on the strength of a same-cycle dequeue.
  assign freeSlots = OCC_W'(DEPTH) - occReg;
  assign inReady   = int'(freeSlots) >= IN_WIDTH;
  assign doEnq     = inReady & ~flush & ~rst & (|effLane);

  // Dequeue requests beyond the current occupancy are clamped.
  always_comb begin
    if (int'(bus.deq_count) > int'(occReg)) begin
      deqEff = occReg;
    end else begin
      deqEff = OCC_W'(bus.deq_count);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next state
  // ---------------------------------------------------------------------------
  always_comb begin
    headNext = headReg;
    tailNext = tailReg;
    occNext  = occReg;
    if (flush) begin
      headNext = '0;
      tailNext = '0;
      occNext  = '0;
    end else begin
      // deqEff may equal DEPTH; truncation to PTR_W gives the modulo wrap.
      headNext = headReg + PTR_W'(deqEff);
      tailNext = tailReg + (doEnq ? PTR_W'(enqCount) : PTR_W'(0));
      occNext  = occReg - deqEff + (doEnq ? enqCount : OCC_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headReg <= '0;
      tailReg <= '0;
      occReg  <= '0;
    end else begin
      headReg <= headNext;
      tailReg <= tailNext;
      occReg  <= occNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload write: each effective lane lands at tail + its compacted offset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (doEnq) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (effLane[i]) begin
          pcMem[tailReg + laneOffset[i]]    <= bus.in_pc[i*PC_WIDTH +: PC_WIDTH];
          insnMem[tailReg + laneOffset[i]]  <= bus.in_insn[i*INSN_WIDTH +: INSN_WIDTH];
          takenMem[tailReg + laneOffset[i]] <= bus.in_pred_taken[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output window: the oldest OUT_WIDTH entries starting at head.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : gOut
    logic [PTR_W-1:0] rdIdx;
    assign rdIdx                                       = headReg + PTR_W'(gi);
    assign bus.out_valid[gi]                           = gi < int'(occReg);
    assign bus.out_pc[gi*PC_WIDTH +: PC_WIDTH]         = pcMem[rdIdx];
    assign bus.out_insn[gi*INSN_WIDTH +: INSN_WIDTH]   = insnMem[rdIdx];
    assign bus.out_pred_taken[gi]                      = takenMem[rdIdx];
  end

  assign bus.in_ready  = inReady;
  assign bus.occupancy = occReg;

endmodule
